// File: rtl/m2_pattern_checker.sv
// Receive-side checker for the M2 test pattern: validates format, pointer sequence,
// counter channels and constants, and tracks pattern lock and error statistics.
module m2_pattern_checker #(
  parameter int         LOCK_WORDS  = 8,
  parameter int         LOSS_ERRORS = 4,
  parameter logic [7:0] CONST_A     = 8'd111,
  parameter logic [7:0] CONST_B     = 8'd222
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wordValid,
  input  logic [7:0]  wordPtr,
  input  logic [11:0] word,
  input  logic        errClear,
  output logic        locked,
  output logic        errPulse,
  output logic [15:0] errCount,
  output logic [3:0]  errFlags
);

  localparam int GW = $clog2(LOCK_WORDS + 1);
  localparam int BW = $clog2(LOSS_ERRORS + 1);

  typedef enum logic [1:0] {UNLOCKED, SYNC, LOCKED} state_t;

  state_t          state, stateNext;
  logic [GW-1:0]   goodCnt, goodNext;
  logic [BW-1:0]   badCnt, badNext;
  logic            dropLock;

  logic [7:0]      lastPtr, ref0, ref1;
  logic            ptrValid, seeded0, seeded1, flag0;

  logic [7:0]      payload, exp0;
  logic [1:0]      ch;
  logic [3:0]      wordFlags, checkFlags;
  logic            wordBad;
  logic [15:0]     countBase, countNext;

  assign payload = word[10:3];
  assign ch      = wordPtr[1:0];
  // ch0 advances only after the words at pointer 0 and 128
  assign exp0    = flag0 ? ref0 + 8'd1 : ref0;

  always_comb begin
    wordFlags    = 4'b0000;
    wordFlags[0] = word[11] | (word[2:0] != 3'b000);
    wordFlags[1] = ptrValid & (wordPtr != lastPtr + 8'd1);
    case (ch)
      2'd0:    wordFlags[2] = seeded0 & (payload != exp0);
      2'd1:    wordFlags[2] = seeded1 & (payload != ref1 - 8'd1);
      2'd2:    wordFlags[3] = (payload != CONST_A);
      default: wordFlags[3] = (payload != CONST_B);
    endcase
    checkFlags = wordValid ? wordFlags : 4'b0000;
    wordBad    = |checkFlags;
  end

  always_comb begin
    stateNext = state;
    goodNext  = goodCnt;
    badNext   = badCnt;
    dropLock  = 1'b0;
    if (wordValid) begin
      case (state)
        UNLOCKED: begin
          if ((seeded0 || ch == 2'd0) && (seeded1 || ch == 2'd1)) begin
            stateNext = SYNC;
            goodNext  = '0;
          end
        end
        SYNC: begin
          if (wordBad) begin
            goodNext = '0;
          end else if (goodCnt + GW'(1) == GW'(LOCK_WORDS)) begin
            stateNext = LOCKED;
            goodNext  = '0;
            badNext   = '0;
          end else begin
            goodNext = goodCnt + GW'(1);
          end
        end
        default: begin
          if (!wordBad) begin
            badNext = '0;
          end else if (badCnt + BW'(1) == BW'(LOSS_ERRORS)) begin
            stateNext = UNLOCKED;
            badNext   = '0;
            dropLock  = 1'b1;
          end else begin
            badNext = badCnt + BW'(1);
          end
        end
      endcase
    end
  end

  // Clear takes effect first so a simultaneous error still lands in the fresh count
  always_comb begin
    countBase = errClear ? 16'd0 : errCount;
    countNext = (wordBad && countBase != 16'hFFFF) ? countBase + 16'd1 : countBase;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= UNLOCKED;
      goodCnt <= '0;
      badCnt  <= '0;
    end else begin
      state   <= stateNext;
      goodCnt <= goodNext;
      badCnt  <= badNext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastPtr  <= 8'd0;
      ptrValid <= 1'b0;
      ref0     <= 8'd0;
      ref1     <= 8'd0;
      flag0    <= 1'b0;
      seeded0  <= 1'b0;
      seeded1  <= 1'b0;
    end else if (wordValid) begin
      lastPtr  <= wordPtr;
      ptrValid <= !dropLock;
      if (ch == 2'd0) begin
        ref0  <= payload;
        flag0 <= (wordPtr == 8'd0) || (wordPtr == 8'd128);
      end
      if (ch == 2'd1) ref1 <= payload;
      if (dropLock) begin
        seeded0 <= 1'b0;
        seeded1 <= 1'b0;
      end else begin
        if (ch == 2'd0) seeded0 <= 1'b1;
        if (ch == 2'd1) seeded1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked   <= 1'b0;
      errPulse <= 1'b0;
      errCount <= 16'd0;
      errFlags <= 4'b0000;
    end else begin
      locked   <= (stateNext == LOCKED);
      errPulse <= wordBad;
      errCount <= countNext;
      errFlags <= (errClear ? 4'b0000 : errFlags) | checkFlags;
    end
  end

endmodule

// File: tb/tb_m2_pattern_checker.sv
// Self-checking bench for m2_pattern_checker: hand vectors, directed corner cases
// and a randomized stream compared against a behavioural pattern model.
module tb_m2_pattern_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wordValid = 1'b0;
  logic [7:0]  wordPtr = 8'd0;
  logic [11:0] word = 12'd0;
  logic        errClear = 1'b0;
  logic        locked, errPulse;
  logic [15:0] errCount;
  logic [3:0]  errFlags;

  int errors = 0;
  int checks = 0;

  m2_pattern_checker dut (
    .clk(clk), .reset(reset), .wordValid(wordValid), .wordPtr(wordPtr),
    .word(word), .errClear(errClear), .locked(locked), .errPulse(errPulse),
    .errCount(errCount), .errFlags(errFlags)
  );

  always #5 clk = ~clk;

  // Reference model: -1 marks an unseeded reference or an unchecked pointer
  int         mState, mRun, mLast, mRef0, mRef1, mCount;
  bit         mBump;
  logic [3:0] mFlags;
  logic       mPulse;

  task automatic modelReset();
    mState = 0; mRun = 0; mLast = -1; mRef0 = -1; mRef1 = -1;
    mCount = 0; mBump = 0; mFlags = 4'b0000; mPulse = 1'b0;
  endtask

  task automatic modelStep(input logic v, input int ptr, input logic [11:0] w, input logic clr);
    int p;
    logic [3:0] f;
    bit bad;
    if (clr) begin
      mCount = 0;
      mFlags = 4'b0000;
    end
    mPulse = 1'b0;
    if (v) begin
      p = int'(w[10:3]);
      f = 4'b0000;
      if (w[11] || w[2:0] != 3'b000) f[0] = 1'b1;
      if (mLast >= 0 && ptr != (mLast + 1) % 256) f[1] = 1'b1;
      case (ptr % 4)
        0: begin
          if (mRef0 >= 0 && p != (mRef0 + (mBump ? 1 : 0)) % 256) f[2] = 1'b1;
          mRef0 = p;
          mBump = (ptr == 0 || ptr == 128);
        end
        1: begin
          if (mRef1 >= 0 && p != (mRef1 + 255) % 256) f[2] = 1'b1;
          mRef1 = p;
        end
        2: if (p != 111) f[3] = 1'b1;
        default: if (p != 222) f[3] = 1'b1;
      endcase
      mLast = ptr;
      bad = (f != 4'b0000);
      if (bad && mCount < 65535) mCount++;
      mFlags = mFlags | f;
      mPulse = bad;
      case (mState)
        0: if (mRef0 >= 0 && mRef1 >= 0) begin mState = 1; mRun = 0; end
        1: begin
          if (bad) mRun = 0;
          else begin
            mRun++;
            if (mRun == 8) begin mState = 2; mRun = 0; end
          end
        end
        default: begin
          if (!bad) mRun = 0;
          else begin
            mRun++;
            if (mRun == 4) begin
              mState = 0; mRun = 0; mRef0 = -1; mRef1 = -1; mLast = -1;
            end
          end
        end
      endcase
    end
  endtask

  // Filler-side generator producing the clean M2 pattern
  logic [7:0] gen0, gen1;
  int         genPtr;

  task automatic genReset();
    gen0 = 8'd0; gen1 = 8'd0; genPtr = 0;
  endtask

  task automatic genNext(output logic [7:0] v);
    case (genPtr % 4)
      0: begin
        v = gen0;
        if (genPtr == 0 || genPtr == 128) gen0 = gen0 + 8'd1;
      end
      1: begin
        v = gen1;
        gen1 = gen1 - 8'd1;
      end
      2: v = 8'd111;
      default: v = 8'd222;
    endcase
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] ptr, input logic [11:0] w, input logic clr);
    wordValid = v;
    wordPtr   = ptr;
    word      = w;
    errClear  = clr;
    modelStep(v, int'(ptr), w, clr);
    @(posedge clk);
    #1;
    wordValid = 1'b0;
    errClear  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic expLocked, input logic expPulse,
                             input logic [15:0] expCount, input logic [3:0] expFlags);
    checks++;
    if ({locked, errPulse, errCount, errFlags} !== {expLocked, expPulse, expCount, expFlags}) begin
      errors++;
      $display("[TB] FAIL %s: got locked=%b pulse=%b count=%0d flags=%b, want locked=%b pulse=%b count=%0d flags=%b",
               name, locked, errPulse, errCount, errFlags, expLocked, expPulse, expCount, expFlags);
    end
  endtask

  task automatic checkModel(input int ptr);
    checkOutput($sformatf("model ptr %0d", ptr), (mState == 2), mPulse, mCount[15:0], mFlags);
  endtask

  task automatic sendWord(input logic [11:0] w, input logic clr);
    int p;
    p = genPtr;
    applyStimulus(1'b1, 8'(genPtr), w, clr);
    checkModel(p);
    genPtr = (genPtr + 1) % 256;
  endtask

  task automatic sendGen(input logic clr);
    logic [7:0] v;
    genNext(v);
    sendWord({1'b0, v, 3'b000}, clr);
  endtask

  task automatic sendClean(input int n);
    for (int i = 0; i < n; i++) sendGen(1'b0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    wordValid = 1'b0;
    errClear = 1'b0;
    modelReset();
    genReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 1'b0, 16'd0, 4'b0000);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  ptr;
    logic [7:0]  pay;
    logic        clr;
    logic        expLocked;
    logic        expPulse;
    logic [15:0] expCount;
    logic [3:0]  expFlags;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [7:0]  v;
    logic [11:0] w;
    int          r;

    vecs[0]  = '{8'd0,  8'd0,   1'b0, 1'b0, 1'b0, 16'd0, 4'b0000};
    vecs[1]  = '{8'd1,  8'd0,   1'b0, 1'b0, 1'b0, 16'd0, 4'b0000};
    vecs[2]  = '{8'd2,  8'd111, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000};
    vecs[3]  = '{8'd3,  8'd222, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000};
    vecs[4]  = '{8'd4,  8'd1,   1'b0, 1'b0, 1'b0, 16'd0, 4'b0000};
    vecs[5]  = '{8'd5,  8'd255, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000};
    vecs[6]  = '{8'd6,  8'd111, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000};
    vecs[7]  = '{8'd7,  8'd222, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000};
    vecs[8]  = '{8'd8,  8'd1,   1'b0, 1'b0, 1'b0, 16'd0, 4'b0000};
    vecs[9]  = '{8'd9,  8'd254, 1'b0, 1'b1, 1'b0, 16'd0, 4'b0000};
    vecs[10] = '{8'd10, 8'd111, 1'b0, 1'b1, 1'b0, 16'd0, 4'b0000};
    vecs[11] = '{8'd11, 8'd222, 1'b0, 1'b1, 1'b0, 16'd0, 4'b0000};
    vecs[12] = '{8'd12, 8'd1,   1'b0, 1'b1, 1'b0, 16'd0, 4'b0000};
    vecs[13] = '{8'd13, 8'd253, 1'b0, 1'b1, 1'b0, 16'd0, 4'b0000};
    vecs[14] = '{8'd14, 8'd110, 1'b0, 1'b1, 1'b1, 16'd1, 4'b1000};
    vecs[15] = '{8'd15, 8'd222, 1'b0, 1'b1, 1'b0, 16'd1, 4'b1000};
    vecs[16] = '{8'd16, 8'd1,   1'b1, 1'b1, 1'b0, 16'd0, 4'b0000};

    $display("[TB] hand vectors");
    doReset();
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].ptr, {1'b0, vecs[i].pay, 3'b000}, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].expLocked, vecs[i].expPulse,
                  vecs[i].expCount, vecs[i].expFlags);
    end

    $display("[TB] directed sequences");
    doReset();
    sendClean(1024);
    checkOutput("clean4frames", 1'b1, 1'b0, 16'd0, 4'b0000);

    sendClean(6);
    genNext(v);
    sendWord({1'b0, 8'd110, 3'b000}, 1'b0);
    checkOutput("ch2Corrupt", 1'b1, 1'b1, 16'd1, 4'b1000);
    sendClean(1);
    checkOutput("afterCorrupt", 1'b1, 1'b0, 16'd1, 4'b1000);

    sendGen(1'b1);
    sendClean(32);
    genPtr = 42;
    sendClean(1);
    checkOutput("ptrSkip", 1'b1, 1'b1, 16'd1, 4'b0010);
    sendClean(1);
    checkOutput("afterSkip", 1'b1, 1'b0, 16'd1, 4'b0010);

    sendGen(1'b1);
    for (int i = 0; i < 4; i++) begin
      genNext(v);
      sendWord({1'b0, v, 3'b001}, 1'b0);
    end
    checkOutput("fmtLoss", 1'b0, 1'b1, 16'd4, 4'b0001);
    sendClean(11);
    checkOutput("syncing", 1'b0, 1'b0, 16'd4, 4'b0001);
    sendClean(1);
    checkOutput("relock", 1'b1, 1'b0, 16'd4, 4'b0001);

    sendClean(198);
    sendGen(1'b1);
    genNext(v);
    v = v + 8'd1;
    gen0 = v;
    sendWord({1'b0, v, 3'b000}, 1'b0);
    checkOutput("ch0Jump", 1'b1, 1'b1, 16'd1, 4'b0100);
    sendClean(4);
    checkOutput("ch0Reseed", 1'b1, 1'b0, 16'd1, 4'b0100);

    sendClean(2);
    genNext(v);
    sendWord({1'b0, 8'd0, 3'b000}, 1'b1);
    checkOutput("clrAndErr", 1'b1, 1'b1, 16'd1, 4'b1000);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncReset", 1'b0, 1'b0, 16'd0, 4'b0000);

    $display("[TB] randomized stream");
    doReset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 15);
      if (r == 3) begin
        applyStimulus(1'b0, 8'd0, 12'd0, 1'b0);
        checkModel(-1);
      end else begin
        if (r == 1) genPtr = (genPtr + 1) % 256;
        genNext(v);
        w = {1'b0, v, 3'b000};
        if (r == 0) w = w ^ (12'd1 << $urandom_range(0, 11));
        if (r == 2) w = {1'b0, 8'($urandom_range(0, 255)), 3'b000};
        sendWord(w, ($urandom_range(0, 31) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m2_pattern_checker.md
Name: m2_pattern_checker

Overview:
- Receive-side counterpart of the M2 group data filler: consumes the 12-bit word stream on the link-capture side and checks it against the M2 test pattern.
- Pattern, by channel = wordPtr[1:0]:
  - ch0: slow up-counter.
  - ch1: per-word down-counter.
  - ch2: constant CONST_A.
  - ch3: constant CONST_B.
- Maintains pattern lock, error counting and sticky error flags for the imitator self-test and status registers.

Parameters:
- LOCK_WORDS, 8, consecutive error-free words required in SYNC before LOCKED.
- LOSS_ERRORS, 4, consecutive erroneous words in LOCKED that drop lock.
- CONST_A, 8'd111, expected payload on ch2.
- CONST_B, 8'd222, expected payload on ch3.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wordValid  in  1  one-cycle strobe; wordPtr/word valid in this cycle.
- wordPtr  in  8  position of the word within the 256-word frame.
- word  in  12  received word, format {1'b0, payload[7:0], 3'b000}.
- errClear  in  1  synchronous clear of errCount and errFlags.
- locked  out  1  high while in LOCKED.
- errPulse  out  1  one-cycle pulse per checked word that has any error.
- errCount  out  16  saturating count of erroneous words (saturates at 16'hFFFF).
- errFlags  out  4  sticky: [0] format, [1] pointer, [2] counter (ch0/ch1), [3] constant (ch2/ch3).

Behaviour:
- Reset (async, active-low): all outputs 0; FSM = UNLOCKED; references, seeded flags and counters cleared.
- Only cycles with wordValid=1 are evaluated. Results are registered: outputs update one clock after the wordValid cycle.
- Format check: error if word[11]!=0 or word[2:0]!=0. Payload p = word[10:3].
- Pointer check:
  - Error if wordPtr != (lastPtr+1) mod 256.
  - 255->0 is legal.
  - Not checked on the first valid word after reset or after entering UNLOCKED.
  - lastPtr is always updated to wordPtr.
- ch2: error if p != CONST_A. ch3: error if p != CONST_B.
- ch0 (wordPtr[1:0]=0):
  - Expected value = ref0, except when the previous ch0 word was at wordPtr 0 or 128; then expected = ref0+1 mod 256.
  - Mismatch is a counter error.
  - ref0 <= p always (re-seed, so no error cascade).
  - flag0 <= (wordPtr==0 || wordPtr==128).
- ch1 (wordPtr[1:0]=1):
  - Expected = ref1-1 mod 256; 0x00 -> 0xFF is legal.
  - Mismatch is a counter error.
  - ref1 <= p always.
- A counter channel is not checked until seeded. The first ch0 (or ch1) word after reset or after entering UNLOCKED only seeds the reference.
- A word is erroneous if any applicable check fails. Each check sets its errFlags bit.
- On an erroneous word: errPulse=1 and errCount increments, in all FSM states.
- FSM:
  - UNLOCKED: go to SYNC once both ch0 and ch1 are seeded; goodCnt=0.
  - SYNC: good word -> goodCnt+1; error -> goodCnt=0. When goodCnt reaches LOCK_WORDS -> LOCKED, and locked=1 from the next cycle.
  - LOCKED: error -> badCnt+1; good word -> badCnt=0. When badCnt reaches LOSS_ERRORS -> UNLOCKED; clear seeded flags and the pointer-check enable; locked=0.
- errClear:
  - Clears errCount and errFlags. Does not affect FSM, references or lock.
  - If errClear and an erroneous word occur in the same cycle, the clear wins for errCount (result 0), then the new error is OR'ed: errFlags = that word's flags, errCount=1.
- Reset mid-frame: state is discarded; re-acquisition restarts from UNLOCKED with seeding.

Test Plan:
- Clean stream from the filler model (ref0=0, ref1=0, pointer 0..255 repeating) -> SYNC after the ch0/ch1 seeds (ptr 0,1); locked=1 after 8 further good words; errCount stays 0 over 4 frames, including ptr 255->0 and ch1 0x00->0xFF wrap.
- While LOCKED, corrupt the ch2 word at ptr 6 to payload 110 -> one errPulse, errFlags=4'b1000, errCount=1; lock held; next word good, badCnt reset.
- While LOCKED, skip ptr 41 (40 followed by 42) -> errFlags[1]=1, errCount=1; the subsequent ptr 43 is good (lastPtr resynced).
- While LOCKED, inject 4 consecutive words with word[0]=1 -> errCount=4, errFlags[0]=1; locked falls one cycle after the 4th; re-lock after re-seed plus 8 good words.
- While LOCKED, ch0 at ptr 4 = ref0+2 -> counter error; re-seeded, so ch0 at ptr 8 with the same value passes; errCount=1.
- Assert errClear in the same cycle as a ch3 error -> errCount=1, errFlags=4'b1000; then assert reset low mid-frame -> all outputs 0 immediately.
